// File: rtl/vga_entity_renderer_pkg.sv
// Shared definitions for the VGA entity renderer: entity codes, colours,
// display modes, the raw timing bundle and the entity-to-colour map.
package vga_entity_renderer_pkg;

    // Default 640x480@60 totals (active + porches + sync)
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    // Entity codes returned by the game logic for each pixel
    typedef enum logic [1:0] {
        ENT_NOTHING    = 2'd0,
        ENT_SNAKE_HEAD = 2'd1,
        ENT_SNAKE_TAIL = 2'd2,
        ENT_APPLE      = 2'd3
    } entity_t;

    // Palette, {R,G,B} nibbles
    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_HEAD   = 12'h0F0;
    localparam logic [11:0] RGB_TAIL   = 12'h0A0;
    localparam logic [11:0] RGB_APPLE  = 12'hF00;
    localparam logic [11:0] RGB_DEAD   = 12'hF00;
    localparam logic [11:0] RGB_WON_BG = 12'h030;

    // Display mode, latched once per frame
    typedef enum logic [1:0] {
        MODE_PLAY = 2'd0,
        MODE_OVER = 2'd1,
        MODE_WON  = 2'd2
    } mode_t;

    // Raw timing decoded from the counters; sync polarities are active-low
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } timing_t;

    // Blanked, syncs idle: the value the alignment pipeline resets to
    localparam timing_t TIMING_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    // Map an entity code to its colour under the current overlays.
    // over_blink: game-over blink phase is lit (snake shown red).
    // won_bg: game won, empty background becomes dark green.
    function automatic logic [11:0] entity_colour(entity_t ent, logic over_blink, logic won_bg);
        logic [11:0] colour;
        colour = RGB_BLACK;
        case (ent)
            ENT_NOTHING:    colour = won_bg ? RGB_WON_BG : RGB_BLACK;
            ENT_SNAKE_HEAD: colour = over_blink ? RGB_DEAD : RGB_HEAD;
            ENT_SNAKE_TAIL: colour = over_blink ? RGB_DEAD : RGB_TAIL;
            ENT_APPLE:      colour = RGB_APPLE;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/vga_entity_renderer_timing_gen.sv
// Pixel/line counters for the VGA raster, plus the raw (unaligned) sync and
// active decode and the start-of-vertical-blank pulse.
module vga_timing_gen
    import vga_entity_renderer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output timing_t    raw,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt_reg;
    logic [9:0] v_cnt_reg;

    // Raster counters: h wraps every line, v advances on each h wrap
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 10'd1;
        end
    end

    // Raw timing decode straight from the registered counters
    always_comb begin
        raw.active = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
        raw.hs_n   = !((h_cnt_reg >= HS_FIRST) && (h_cnt_reg < HS_STOP));
        raw.vs_n   = !((v_cnt_reg >= VS_FIRST) && (v_cnt_reg < VS_STOP));
    end

    assign h_cnt       = h_cnt_reg;
    assign v_cnt       = v_cnt_reg;
    assign frame_start = (h_cnt_reg == 10'd0) && (v_cnt_reg == V_ACT);

endmodule

// File: rtl/vga_entity_renderer.sv
// VGA renderer: drives pixel coordinates to the game logic, takes the entity
// code back ENT_LATENCY cycles later, colours it with per-frame mode overlays
// and emits colour, syncs and blank aligned with each other.
module vga_entity_renderer
    import vga_entity_renderer_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int ENT_LATENCY = 1,
    parameter int BLINK_LOG2  = 5
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [1:0]  entity,
    input  logic        game_over,
    input  logic        game_won,
    output logic [9:0]  x_out,
    output logic [9:0]  y_out,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [11:0] rgb,
    output logic        frame_start
);

    timing_t     raw;
    timing_t     chain [ENT_LATENCY+1];
    timing_t     aligned;
    mode_t       mode_reg;
    mode_t       mode_next;
    logic [7:0]  frame_cnt_reg;
    logic        blink;
    logic        over_blink;
    logic        won_bg;
    logic [11:0] pix_colour;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .h_cnt       (x_out),
        .v_cnt       (y_out),
        .raw         (raw),
        .frame_start (frame_start)
    );

    // Delay line so raw timing lines up with the returning entity code
    assign chain[0] = raw;
    generate
        for (genvar gi = 0; gi < ENT_LATENCY; gi++) begin : g_align
            timing_t stage_reg;

            // One stage of the timing delay line
            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    stage_reg <= TIMING_IDLE;
                end else begin
                    stage_reg <= chain[gi];
                end
            end

            assign chain[gi+1] = stage_reg;
        end
    endgenerate
    assign aligned = chain[ENT_LATENCY];

    // Mode state register
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            mode_reg <= MODE_PLAY;
        end else begin
            mode_reg <= mode_next;
        end
    end

    // Next mode: game status sampled only at vertical-blank start, won wins
    always_comb begin
        mode_next = mode_reg;
        if (frame_start) begin
            if (game_won) begin
                mode_next = MODE_WON;
            end else if (game_over) begin
                mode_next = MODE_OVER;
            end else begin
                mode_next = MODE_PLAY;
            end
        end
    end

    // Overlay controls decoded from the current mode
    always_comb begin
        over_blink = (mode_reg == MODE_OVER) && blink;
        won_bg     = (mode_reg == MODE_WON);
    end

    // Frame counter driving the game-over blink
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            frame_cnt_reg <= '0;
        end else if (frame_start) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign blink      = frame_cnt_reg[BLINK_LOG2];
    assign pix_colour = entity_colour(entity_t'(entity), over_blink, won_bg);

    // Output register: colour, blank and syncs leave together
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            rgb      <= '0;
        end else begin
            hsync    <= aligned.hs_n;
            vsync    <= aligned.vs_n;
            video_on <= aligned.active;
            rgb      <= aligned.active ? pix_colour : '0;
        end
    end

endmodule

// File: tb/tb_vga_entity_renderer.sv
// Bench for vga_entity_renderer. A reduced-size raster instance carries the
// functional tests (whole frames fit in a short run); a default-size instance
// pins the real 640x480 horizontal timing over its first two lines.
module tb_vga_entity_renderer;
    import vga_entity_renderer_pkg::*;

    // Reduced raster for the main instance
    localparam int SH_A = 40, SH_FP = 4, SH_S = 8, SH_B = 6;
    localparam int SV_A = 30, SV_FP = 3, SV_S = 2, SV_B = 4;
    localparam int SBL  = 1;
    localparam int HT = SH_A + SH_FP + SH_S + SH_B;   // 58
    localparam int VT = SV_A + SV_FP + SV_S + SV_B;   // 39
    localparam int FRAME = HT * VT;                   // 2262

    typedef struct packed { bit hs_n; bit vs_n; bit von; } tim_t;

    logic        vga_clk;
    logic        reset;
    logic [1:0]  entity;
    logic        game_over;
    logic        game_won;
    logic [9:0]  x_out, y_out;
    logic        hsync, vsync, video_on, frame_start;
    logic [11:0] rgb;

    logic [1:0]  b_entity;
    logic        b_go, b_gw;
    logic [9:0]  b_x, b_y;
    logic        b_hsync, b_vsync, b_von, b_fs;
    logic [11:0] b_rgb;

    vga_entity_renderer #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_B),
        .ENT_LATENCY(1), .BLINK_LOG2(SBL)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .entity(entity),
        .game_over(game_over), .game_won(game_won),
        .x_out(x_out), .y_out(y_out), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .rgb(rgb), .frame_start(frame_start)
    );

    vga_entity_renderer dut_full (
        .vga_clk(vga_clk), .reset(reset), .entity(b_entity),
        .game_over(b_go), .game_won(b_gw),
        .x_out(b_x), .y_out(b_y), .hsync(b_hsync), .vsync(b_vsync),
        .video_on(b_von), .rgb(b_rgb), .frame_start(b_fs)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Scoreboard counters and model state
    int pass_cnt = 0;
    int total_cnt = 0;
    int n = 0;            // cycles since reset release
    int m_mode = 0;       // 0 play, 1 over, 2 won
    int m_fcnt = 0;
    int ent_phase = 4;
    int epoch = 0;
    bit chk_en = 0;
    int prev_x = 0, prev_y = 0;

    int hs_fall = -1, hs_low_line0 = 0, vs_low_f0 = 0, fs_cnt_f0 = 0, fs_n_f0 = -1;
    int big_fall = -1, big_low = 0;
    int apple_cnt = 0, n_apple = -1, n_xy = -1;

    task automatic chk(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, n);
    endtask

    function automatic tim_t raw_timing(int h, int v, int ha, int hfp, int hsw,
                                        int va, int vfp, int vsw);
        tim_t t;
        t.hs_n = !(h >= ha + hfp && h < ha + hfp + hsw);
        t.vs_n = !(v >= va + vfp && v < va + vfp + vsw);
        t.von  = (h < ha) && (v < va);
        return t;
    endfunction

    // What the game logic reports at (x,y) for each test phase
    function automatic logic [1:0] ent_at(int ph, int x, int y);
        case (ph)
            1:       return (x == 20 && y == 10) ? ENT_APPLE : ENT_NOTHING;
            2:       return ENT_SNAKE_HEAD;
            3:       return 2'((x + y) % 4);
            4:       return ENT_APPLE;
            default: return ENT_NOTHING;
        endcase
    endfunction

    function automatic logic [11:0] model_colour(logic [1:0] ent, int mode, bit blk);
        case (ent)
            2'd0:    return (mode == 2) ? 12'h030 : 12'h000;
            2'd1:    return (mode == 1 && blk) ? 12'hF00 : 12'h0F0;
            2'd2:    return (mode == 1 && blk) ? 12'hF00 : 12'h0A0;
            default: return 12'hF00;
        endcase
    endfunction

    // One clock: advance the model, then act as the game logic (one-cycle
    // registered entity lookup of the coordinate seen in the previous cycle)
    task automatic tick();
        bit fs_pend, go_s, gw_s;
        fs_pend = !reset && (n % HT == 0) && ((n / HT) % VT == SV_A);
        go_s = game_over;
        gw_s = game_won;
        @(posedge vga_clk);
        if (!reset) begin
            if (fs_pend) begin
                m_mode = gw_s ? 2 : (go_s ? 1 : 0);
                m_fcnt = (m_fcnt + 1) % 256;
            end
            n++;
        end
        #1;
        entity = ent_at(ent_phase, prev_x, prev_y);
        prev_x = int'(x_out);
        prev_y = int'(y_out);
    endtask

    task automatic goto(int x, int y);
        int k;
        k = 0;
        tick();
        while (!((n % HT) == x && ((n / HT) % VT) == y) && k < 2 * FRAME) begin
            tick();
            k++;
        end
        if (k >= 2 * FRAME) chk("goto_bound", k, 0);
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge vga_clk) begin : cmp
        int mx, my, hp, vp;
        tim_t t;
        logic [11:0] ergb;
        if (chk_en) begin
            mx = n % HT;
            my = (n / HT) % VT;
            chk("x_out", int'(x_out), mx);
            chk("y_out", int'(y_out), my);
            chk("frame_start", int'(frame_start), int'(mx == 0 && my == SV_A));
            if (n < 2) begin
                t = '{hs_n: 1'b1, vs_n: 1'b1, von: 1'b0};
                ergb = 12'h000;
            end else begin
                hp = (n - 2) % HT;
                vp = ((n - 2) / HT) % VT;
                t = raw_timing(hp, vp, SH_A, SH_FP, SH_S, SV_A, SV_FP, SV_S);
                ergb = t.von ? model_colour(ent_at(ent_phase, hp, vp), m_mode,
                                            bit'((m_fcnt >> SBL) & 1)) : 12'h000;
            end
            chk("hsync", int'(hsync), int'(t.hs_n));
            chk("vsync", int'(vsync), int'(t.vs_n));
            chk("video_on", int'(video_on), int'(t.von));
            chk("rgb", int'(rgb), int'(ergb));

            if (ent_phase == 1) begin
                if (x_out == 10'd20 && y_out == 10'd10) n_xy = n;
                if (rgb == 12'hF00) begin
                    apple_cnt++;
                    n_apple = n;
                end
            end

            if (epoch == 0) begin
                if (n < HT && !hsync) begin
                    hs_low_line0++;
                    if (hs_fall < 0) hs_fall = n;
                end
                if (n < FRAME && !vsync) vs_low_f0++;
                if (n < FRAME && frame_start) begin
                    fs_cnt_f0++;
                    fs_n_f0 = n;
                end
                if (n < 1700) begin
                    chk("full_x_out", int'(b_x), n % 800);
                    chk("full_y_out", int'(b_y), n / 800);
                    chk("full_frame_start", int'(b_fs), int'((n % 800) == 0 && (n / 800) == 480));
                    if (n < 2) t = '{hs_n: 1'b1, vs_n: 1'b1, von: 1'b0};
                    else t = raw_timing((n - 2) % 800, (n - 2) / 800, 640, 16, 96, 480, 10, 2);
                    chk("full_hsync", int'(b_hsync), int'(t.hs_n));
                    chk("full_vsync", int'(b_vsync), int'(t.vs_n));
                    chk("full_video_on", int'(b_von), int'(t.von));
                    chk("full_rgb", int'(b_rgb), t.von ? 32'hF00 : 0);
                    if (n < 800 && !b_hsync) begin
                        big_low++;
                        if (big_fall < 0) big_fall = n;
                    end
                end
            end
        end
    end

    logic [11:0] blink_seq [5];

    initial begin
        blink_seq = '{12'hF00, 12'h0F0, 12'h0F0, 12'hF00, 12'hF00};
        reset = 1'b1;
        game_over = 1'b0;
        game_won = 1'b0;
        entity = ENT_NOTHING;
        b_entity = ENT_APPLE;
        b_go = 1'b0;
        b_gw = 1'b0;
        ent_phase = 4;
        tick();
        chk_en = 1;
        tick();
        tick();
        reset = 1'b0;

        // Frame 0: apple everywhere, raster timing and blanking
        goto(0, 36);
        chk("hs_first_fall", hs_fall, 46);
        chk("hs_low_per_line", hs_low_line0, 8);
        chk("vs_low_cycles", vs_low_f0, 116);
        chk("frame_start_count", fs_cnt_f0, 1);
        chk("frame_start_cycle", fs_n_f0, 1740);
        chk("full_hs_first_fall", big_fall, 658);
        chk("full_hs_low_per_line", big_low, 96);

        // Frame 1: a single apple at (20,10)
        ent_phase = 1;
        goto(0, 36);
        chk("apple_pixels", apple_cnt, 1);
        chk("apple_latency", n_apple - n_xy, 2);

        // Frame 2: head everywhere, game_over raised mid-frame
        ent_phase = 2;
        goto(25, 12);
        game_over = 1'b1;
        goto(27, 20);
        chk("head_before_frame_start", int'(rgb), 12'h0F0);
        for (int f = 0; f < 5; f++) begin
            goto(27, 20);
            chk($sformatf("head_blink_f%0d", f + 3), int'(rgb), int'(blink_seq[f]));
        end

        // Won together with over: WON takes effect one frame after sampling
        goto(0, 36);
        game_won = 1'b1;
        ent_phase = 3;
        goto(0, 36);
        goto(22, 12);
        chk("won_nothing", int'(rgb), 12'h030);
        goto(23, 13);
        chk("won_tail", int'(rgb), 12'h0A0);
        goto(47, 13);
        chk("won_hblank_rgb", int'(rgb), 0);
        chk("won_hblank_von", int'(video_on), 0);

        // Asynchronous reset mid-line
        goto(25, 14);
        chk("pre_reset_x", int'(x_out), 25);
        #2;
        reset = 1'b1;
        n = 0;
        m_mode = 0;
        m_fcnt = 0;
        epoch = 1;
        #1;
        chk("async_x_out", int'(x_out), 0);
        chk("async_y_out", int'(y_out), 0);
        chk("async_video_on", int'(video_on), 0);
        chk("async_rgb", int'(rgb), 0);
        chk("async_hsync", int'(hsync), 1);
        chk("async_vsync", int'(vsync), 1);
        tick();
        tick();
        reset = 1'b0;
        chk("restart_x0", int'(x_out), 0);
        tick();
        chk("restart_x1", int'(x_out), 1);
        tick();
        chk("restart_x2", int'(x_out), 2);
        goto(12, 2);
        chk("mode_play_after_reset", int'(rgb), 12'h000);
        chk("active_after_reset", int'(video_on), 1);
        goto(0, 31);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
